multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max consecutive wait cycles for mem_ready in any memory state (1..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access complete this cycle.
REQ-008 iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen  output  1 each  datapath controls.
REQ-009 alusrcb  output  2  00 = RD2, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
REQ-010 aluctl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-011 pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-012 state  output  4  current state code; retire  output  1  one-cycle pulse at instruction completion; halted  output  1  TRAP indicator.

Function
REQ-013 The states and codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12; codes 13-15 SHALL go to TRAP on the next edge.
REQ-014 All outputs SHALL be combinational from state and inputs; unlisted controls SHALL be 0, with aluctl defaulting to 010.
REQ-015 FETCH: alusrcb=01; irwrite=pcen=mem_ready; advance to DECODE only when mem_ready=1, else hold.
REQ-016 DECODE: alusrcb=11; next state by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP; any other opcode -> TRAP.
REQ-017 MEMADR: alusrca=1, alusrcb=10; next MEMRD for lw, MEMWR for sw.
REQ-018 MEMRD: iord=1; hold until mem_ready, then MEMWB.
REQ-019 MEMWB: memtoreg=1, regwrite=1, retire=1; next FETCH.
REQ-020 MEMWR: iord=1, memwrite=1, retire=mem_ready; hold until mem_ready, then FETCH.
REQ-021 EXEC: alusrca=1, alusrcb=00; aluctl from funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct -> TRAP, else ALUWB.
REQ-022 ALUWB: regdst=1, regwrite=1, retire=1; next FETCH.
REQ-023 BRANCH: alusrca=1, aluctl=110, pcsrc=01, pcen=zero, retire=1; next FETCH.
REQ-024 ADDIEX: alusrca=1, alusrcb=10; next ADDIWB. ADDIWB: regwrite=1, retire=1; next FETCH.
REQ-025 JUMP: pcsrc=10, pcen=1, retire=1; next FETCH.
REQ-026 An 8-bit wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and increment each cycle mem_ready=0 there; when it reaches TIMEOUT with mem_ready still 0, next state SHALL be TRAP.
REQ-027 mem_ready=1 on the cycle the counter reaches TIMEOUT SHALL complete the access normally.
REQ-028 TRAP: halted=1, all write enables 0; remain until reset.
REQ-029 mem_ready SHALL be ignored in states other than FETCH, MEMRD, MEMWR.

Reset
REQ-030 reset SHALL force state=FETCH and wait counter=0 immediately, mid-instruction included.
REQ-031 While reset is high, irwrite, memwrite, regwrite, pcen, retire and halted SHALL be 0.
REQ-032 The first FETCH SHALL begin on the first rising edge after reset deasserts.

Configuration
REQ-033 Macro MULTICYCLE_JUMP_EN: defined -> opcode 000010 decodes to JUMP; undefined -> JUMP state absent, opcode 000010 goes to TRAP, code 11 treated as illegal.

Verification
REQ-034 lw (100011), mem_ready always 1 -> states 0,1,2,3,4,0; regwrite and memtoreg=1 only in state 4; retire once.
REQ-035 add R-type (funct 100000), then sub (100010) -> aluctl 010 then 110 in EXEC; 4 cycles each; regdst=1 in ALUWB.
REQ-036 beq with zero=1 then zero=0 -> pcen=1 then 0 in BRANCH; pcsrc=01 both.
REQ-037 sw with mem_ready low 3 cycles in MEMWR -> memwrite held 4 cycles, retire on 4th only; TIMEOUT=2, mem_ready never -> TRAP, halted=1.
REQ-038 opcode 111111 -> TRAP after DECODE; j without MULTICYCLE_JUMP_EN -> TRAP, with it -> pcsrc=10, pcen=1.
REQ-039 reset asserted in MEMRD -> state=0, all enables 0 immediately; fetch resumes after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM with memory wait timeout
// Optional jump support: define MULTICYCLE_JUMP_EN.
module multicycle_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [2:0] aluctl,
    output logic [1:0] pcsrc,
    output logic [3:0] state,
    output logic       retire,
    output logic       halted
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
`ifdef MULTICYCLE_JUMP_EN
        JUMP   = 4'd11,
`endif
        TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic       mem_state;
    logic       timed_out;

    assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timed_out = (wait_cnt == TIMEOUT_C);
    assign state     = state_q;

    // Counter restarts on every state change, so each memory access gets a fresh budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            wait_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                wait_cnt <= 8'd0;
            else if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        pcen     = 1'b0;
        alusrcb  = 2'b00;
        aluctl   = 3'b010;
        pcsrc    = 2'b00;
        retire   = 1'b0;
        halted   = 1'b0;

        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                if (mem_ready)      state_d = DECODE;
                else if (timed_out) state_d = TRAP;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (opcode == OP_LW)      state_d = MEMRD;
                else if (opcode == OP_SW) state_d = MEMWR;
                else                      state_d = TRAP;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready)      state_d = MEMWB;
                else if (timed_out) state_d = TRAP;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = mem_ready;
                if (mem_ready)      state_d = FETCH;
                else if (timed_out) state_d = TRAP;
            end
            EXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                state_d = ALUWB;
                case (funct)
                    6'b100000: aluctl = 3'b010;
                    6'b100010: aluctl = 3'b110;
                    6'b100100: aluctl = 3'b000;
                    6'b100101: aluctl = 3'b001;
                    6'b101010: aluctl = 3'b111;
                    default:   state_d = TRAP;
                endcase
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluctl  = 3'b110;
                pcsrc   = 2'b01;
                pcen    = zero;
                retire  = 1'b1;
                state_d = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
`ifdef MULTICYCLE_JUMP_EN
            JUMP: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
`endif
            TRAP: begin
                halted  = 1'b1;
                state_d = TRAP;
            end
            default: state_d = TRAP;
        endcase

        // FETCH is entered asynchronously on reset; keep its enables quiet until release.
        if (reset) begin
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            pcen     = 1'b0;
            retire   = 1'b0;
            halted   = 1'b0;
        end
    end

endmodule
